// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// State encoding and operand-forward select encoding.
package pipe_ctrl_pkg;

  localparam int REG_AW  = 3;
  localparam int SHAMT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    FWD_RF = 1'b0,
    FWD_WB = 1'b1
  } fwd_sel_e;

endpackage

// File: rtl/pipe_fwd_unit.sv
// WB-to-EX operand forward comparator.
// Purely combinational; register 0 is treated like any other.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [REG_AW-1:0] ex_source1,
  input  logic [REG_AW-1:0] ex_source2,
  input  logic              ex_alu_src,
  output logic              fwd_a,
  output logic              fwd_b
);

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  // pick the WB result when it targets an EX source register
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (wb_regwrite &&
        (wb_write_reg == ex_source1))
      sel_a = FWD_WB;
    if (wb_regwrite && !ex_alu_src &&
        (wb_write_reg == ex_source2))
      sel_b = FWD_WB;
  end

  assign fwd_a = (sel_a == FWD_WB);
  assign fwd_b = (sel_b == FWD_WB);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: iterative-shift sequencing,
// stall/bubble generation, forwarding, stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_is_shift,
  input  logic [SHAMT_W-1:0] ex_shamt,
  input  logic [REG_AW-1:0]  ex_source1,
  input  logic [REG_AW-1:0]  ex_source2,
  input  logic               ex_alu_src,
  input  logic               wb_regwrite,
  input  logic [REG_AW-1:0]  wb_write_reg,
  input  logic               perf_clr,
  output logic               stall_pc,
  output logic               stall_ifid,
  output logic               stall_idex,
  output logic               exwb_bubble,
  output logic               shift_load,
  output logic               shift_en,
  output logic               fwd_a,
  output logic               fwd_b,
  output logic               busy,
  output logic [CNT_W-1:0]   stall_count
);

  state_e             state_q;
  state_e             state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               stall_raw;
  logic               load_raw;
  logic               en_raw;
  logic               stall;
  logic               fwd_a_raw;
  logic               fwd_b_raw;

  // next state, remaining shift steps and raw controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    load_raw  = 1'b0;
    en_raw    = 1'b0;
    unique case (state_q)
      RUN: begin
        load_raw = ex_valid && ex_is_shift;
        en_raw   = load_raw &&
                   (ex_shamt != '0);
        if (load_raw &&
            (ex_shamt >= SHAMT_W'(2))) begin
          stall_raw = 1'b1;
          state_d   = SHIFT;
          cnt_d     = ex_shamt - SHAMT_W'(1);
        end
      end
      SHIFT: begin
        en_raw = 1'b1;
        if (cnt_q > SHAMT_W'(1)) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - SHAMT_W'(1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // state and step counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // saturating stall counter, clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
    end else if (stall &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  pipe_fwd_unit u_fwd (
    .wb_regwrite  (wb_regwrite),
    .wb_write_reg (wb_write_reg),
    .ex_source1   (ex_source1),
    .ex_source2   (ex_source2),
    .ex_alu_src   (ex_alu_src),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  // combinational outputs are forced low while reset is held
  assign stall       = stall_raw & reset;
  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign stall_idex  = stall;
  assign exwb_bubble = stall;
  assign shift_load  = load_raw & reset;
  assign shift_en    = en_raw & reset;
  assign fwd_a       = fwd_a_raw & reset;
  assign fwd_b       = fwd_b_raw & reset;
  assign busy        = (state_q == SHIFT);
  assign stall_count = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 4-stage 8-bit core. It sequences the iterative shifter in EX, which shifts 1 bit per cycle. While the shifter is busy it stalls the PC, IF/ID and ID/EX registers and bubbles EX/WB. It also generates WB-to-EX operand-forward selects and keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 3, register-address width (8 architectural registers)
SHAMT_W, 3, used shift-amount bits (shamt[2:0], 0..7)
CNT_W, 16, stall performance counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ex_valid  input  1  ID/EX holds a real instruction
ex_is_shift  input  1  EX instruction is a shift (alu_sel path)
ex_shamt  input  SHAMT_W  shift amount of the EX instruction
ex_source1  input  REG_AW  EX operand-1 register
ex_source2  input  REG_AW  EX operand-2 register
ex_alu_src  input  1  1 = operand 2 is immediate/shamt, so no forward on operand 2
wb_regwrite  input  1  WB stage writes the register file
wb_write_reg  input  REG_AW  WB destination
perf_clr  input  1  synchronous clear of stall_count
stall_pc  output  1  hold PC
stall_ifid  output  1  hold IF/ID
stall_idex  output  1  hold ID/EX
exwb_bubble  output  1  load EX/WB with regwrite=0
shift_load  output  1  shifter loads operand (first shift cycle)
shift_en  output  1  shifter performs 1-bit step this cycle
fwd_a  output  1  1 = EX operand 1 taken from WB result
fwd_b  output  1  1 = EX operand 2 taken from WB result
busy  output  1  controller in SHIFT state
stall_count  output  CNT_W  number of stalled cycles, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, cnt=0, stall_count=0. All outputs are 0 during reset.
- State is registered as RUN or SHIFT. cnt is SHAMT_W bits.
- start = (state==RUN) && ex_valid && ex_is_shift && (ex_shamt>=2).
- In RUN:
  - shift_load = ex_valid && ex_is_shift.
  - shift_en = shift_load && (ex_shamt!=0).
  - If start: stall = 1, next state = SHIFT, cnt <= ex_shamt-1.
  - Otherwise stall = 0 and the state stays RUN.
- In SHIFT:
  - shift_en = 1, shift_load = 0. ex_* inputs are ignored.
  - If cnt>1: stall = 1 and cnt <= cnt-1.
  - If cnt==1 (final cycle): stall = 0, next state = RUN, cnt <= 0.
- stall_pc = stall_ifid = stall_idex = exwb_bubble = stall. These are combinational from state, cnt and the ex_* inputs.
- busy = (state==SHIFT).
- Shift latency:
  - shamt 0 or 1: 1 EX cycle, no stall.
  - shamt s>=2: EX occupies s cycles and stall is high for exactly s-1 consecutive cycles.
  - The next instruction enters EX on the cycle after the final cycle.
- No retrigger: the final SHIFT cycle releases ID/EX, so the next RUN cycle sees the new instruction.
- Forwarding (combinational):
  - fwd_a = wb_regwrite && (wb_write_reg==ex_source1).
  - fwd_b = wb_regwrite && !ex_alu_src && (wb_write_reg==ex_source2).
  - Register 0 is not special.
  - Forwarding is evaluated in every state. During SHIFT the bubbled EX/WB has regwrite=0, so forwarding self-disables.
- stall_count:
  - Increments by 1 on every clock edge where stall=1, saturating at all-ones (no wrap).
  - perf_clr is synchronous. If perf_clr and stall occur in the same cycle, the result is 0 (clear wins).
- Reset mid-SHIFT aborts immediately: RUN, cnt=0, stalls drop asynchronously.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, SHIFT}, REG_AW and SHAMT_W constants, and the forward-select encoding.
- One sub-module, pipe_fwd_unit: purely combinational fwd_a/fwd_b comparator, instantiated once.
- The FSM, cnt and stall_count stay in pipe_hazard_ctrl.

Test Plan:
1. Reset release, ex_valid=0 for 5 cycles -> all outputs 0, stall_count=0, busy=0.
2. EX shift shamt=5 at cycle T -> stall high T..T+3 (4 cycles). shift_load at T only; shift_en T..T+4; busy T+1..T+4; stall_count=4.
3. shamt=1 then shamt=0 back-to-back -> no stall. shift_en=1 for the first only, shift_load=1 for both.
4. wb_regwrite=1, wb_write_reg=3, ex_source1=3, ex_source2=3, ex_alu_src=1 -> fwd_a=1, fwd_b=0. Same with ex_alu_src=0 -> fwd_b=1. Same with wb_regwrite=0 -> both 0.
5. Start shamt=7, assert reset low at 3rd stall cycle -> stalls drop immediately, busy=0. After release, a new shamt=2 produces a 1-cycle stall.
6. Preload stall_count=16'hFFFE, then 3 stall cycles -> holds 16'hFFFF. perf_clr together with stall -> 0.
